wave_capture: RTL and testbench

//  Triggered sample capture upstream of the VGA waveform renderer. Writes ADC samples into
//  a ping-pong pair of DEPTH-entry banks around a level/edge trigger; the renderer reads the

---
 rtl/wave_pkg.sv | 24 ++
 rtl/wave_capture_sample_ram.sv | 35 +++
 rtl/wave_capture.sv | 213 +++++++++++++++++++++
 tb/tb_wave_capture.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared capture-state type, default geometry and
// the circular write-pointer increment used by wave_capture.
package wave_pkg;

  localparam int WAVE_DEPTH = 640;
  localparam int WAVE_DW    = 8;
  localparam int WAVE_AW    = 10;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  function automatic logic [WAVE_AW-1:0] wrap_inc(
    input logic [WAVE_AW-1:0] p,
    input int                 depth
  );
    return (p == WAVE_AW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/wave_capture_sample_ram.sv
// sample_ram: two-bank sample store, 2*DEPTH x DW.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata (1-cycle).
// Address is {bank, addr}; bank 1 is packed directly after bank 0.
module sample_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 8,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] OFS = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [2*DEPTH];
  logic [AW:0]   widx;
  logic [AW:0]   ridx;

  assign widx = waddr[AW] ? {1'b0, waddr[AW-1:0]} + OFS
                          : {1'b0, waddr[AW-1:0]};
  assign ridx = raddr[AW] ? {1'b0, raddr[AW-1:0]} + OFS
                          : {1'b0, raddr[AW-1:0]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/wave_capture.sv
// wave_capture: triggered ping-pong sample capture for the VGA
// waveform renderer. Banks swap only on frame_sync in DONE.
// Ports: clk, rst_n (async low); sample_valid/sample_data in;
// trig_level, trig_rising, single_shot, arm, frame_sync control;
// rd_x -> rd_data (1 cycle); frame_ready, triggered, busy status.
// Option: WAVE_AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT
// valid samples in ARMED.
module wave_capture
  import wave_pkg::*;
#(
  parameter int DEPTH        = WAVE_DEPTH,
  parameter int DW           = WAVE_DW,
  parameter int PRE_TRIG     = 64,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [DW-1:0]      sample_data,
  input  logic [DW-1:0]      trig_level,
  input  logic               trig_rising,
  input  logic               single_shot,
  input  logic               arm,
  input  logic               frame_sync,
  input  logic [WAVE_AW-1:0] rd_x,
  output logic [DW-1:0]      rd_data,
  output logic               frame_ready,
  output logic               triggered,
  output logic               busy
);

  localparam int AW     = WAVE_AW;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [AW-1:0] PT      = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PT_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] PT_WRAP = AW'(DEPTH - PRE_TRIG);
  localparam logic [AW-1:0] PO_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0] D_AW    = AW'(DEPTH);
  localparam logic [AW:0]   D_X     = (AW+1)'(DEPTH);

  cap_state_t state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] start_q, start_d;
  logic [AW-1:0] rd_start_q;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   sum;
  logic [AW:0]   waddr;
  logic [AW:0]   raddr;
  logic [DW-1:0] prev_q;
  logic [DW-1:0] ram_q;

  logic wr_bank_q;
  logic rd_bank_q;
  logic ready_q;
  logic trig_q, trig_d;
  logic zero_q;
  logic swap;
  logic we;
  logic edge_hit;
  logic auto_hit;

  assign edge_hit = trig_rising
    ? (prev_q <  trig_level && sample_data >= trig_level)
    : (prev_q >= trig_level && sample_data <  trig_level);

`ifdef WAVE_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != ARMED) begin
      to_cnt_q <= '0;
    end else if (sample_valid) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // This sample is the AUTO_TIMEOUT-th one seen while armed.
  assign auto_hit = (to_cnt_q == TW'(AUTO_TIMEOUT - 1));
`else
  // Timeout is inert in this build; ARMED waits for a real edge.
  assign auto_hit = (AUTO_TIMEOUT < 0);
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    start_d  = start_q;
    trig_d   = trig_q;
    swap     = 1'b0;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = PRE;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      PRE: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_ptr_d = wrap_inc(wr_ptr_q, DEPTH);
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == PT_LAST) begin
            state_d = ARMED;
            cnt_d   = '0;
          end
        end
      end
      ARMED: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_ptr_d = wrap_inc(wr_ptr_q, DEPTH);
          if (edge_hit || auto_hit) begin
            // Frame starts PRE_TRIG slots before the trigger slot.
            start_d = (wr_ptr_q >= PT) ? wr_ptr_q - PT
                                       : wr_ptr_q + PT_WRAP;
            trig_d  = 1'b1;
            cnt_d   = '0;
            state_d = (POST_N == 0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_ptr_d = wrap_inc(wr_ptr_q, DEPTH);
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == PO_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (frame_sync) begin
          swap     = 1'b1;
          trig_d   = 1'b0;
          wr_ptr_d = '0;
          cnt_d    = '0;
          state_d  = single_shot ? IDLE : PRE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      start_q    <= '0;
      rd_start_q <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      ready_q    <= 1'b0;
      trig_q     <= 1'b0;
      prev_q     <= '0;
      zero_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      trig_q   <= trig_d;
      if (sample_valid) begin
        prev_q <= sample_data;
      end
      if (swap) begin
        rd_bank_q  <= wr_bank_q;
        rd_start_q <= start_q;
        wr_bank_q  <= ~wr_bank_q;
        ready_q    <= 1'b1;
      end
      // Blank the read while no frame exists or column is off-screen.
      zero_q <= !ready_q || (rd_x >= D_AW);
    end
  end

  assign sum     = {1'b0, rd_start_q} + {1'b0, rd_x};
  assign rd_addr = (sum >= D_X) ? AW'(sum - D_X) : sum[AW-1:0];
  assign raddr   = {rd_bank_q, rd_addr};
  assign waddr   = {wr_bank_q, wr_ptr_q};

  sample_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (sample_data),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign rd_data     = zero_q ? '0 : ram_q;
  assign frame_ready = ready_q;
  assign triggered   = trig_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: randomized stimulus against a frame-history model.
// The model rebuilds each displayed frame from the sample stream.
module tb_wave_capture;

  localparam int DEPTH     = 640;
  localparam int PT        = 64;
  localparam int AUTO_TO   = 16;
  localparam int POST_N    = DEPTH - PT - 1;
  localparam int FS_PERIOD = 700;

`ifdef WAVE_AUTO_TRIG_EN
  localparam int UP_T   = PT + AUTO_TO - 1;
  localparam int DN_T   = 255 - (PT + AUTO_TO - 1);
  localparam int S5_R0  = 15;
  localparam int S5_T   = 79;
  localparam int S5_END = 54;
`else
  localparam int UP_T   = 128;
  localparam int DN_T   = 99;
  localparam int S5_R0  = 86;
  localparam int S5_T   = 200;
  localparam int S5_END = 25;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = '0;
  logic [7:0] trig_level = '0;
  logic       trig_rising = 1'b1;
  logic       single_shot = 1'b0;
  logic       arm = 1'b0;
  logic       frame_sync = 1'b0;
  logic [9:0] rd_x = '0;
  logic [7:0] rd_data;
  logic       frame_ready;
  logic       triggered;
  logic       busy;

  always #5 clk = ~clk;

  wave_capture #(
    .DEPTH        (DEPTH),
    .DW           (8),
    .PRE_TRIG     (PT),
    .AUTO_TIMEOUT (AUTO_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .single_shot  (single_shot),
    .arm          (arm),
    .frame_sync   (frame_sync),
    .rd_x         (rd_x),
    .rd_data      (rd_data),
    .frame_ready  (frame_ready),
    .triggered    (triggered),
    .busy         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int mode = 0;
  int seq = 0;
  int cyc = 0;
  int valid_pct = 80;
  int rd_fix = -1;
  bit fs_auto = 1'b0;
  bit fs_once = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 pre, 2 armed, 3 post, 4 done.
  int m_phase = 0;
  int m_cap[$];
  int m_show[DEPTH];
  int m_prev = 0;
  int m_tidx = 0;
  int m_post = 0;
  int m_armed = 0;
  int m_rd = 0;
  int m_cur;
  int m_lvl;
  bit m_ready = 1'b0;
  bit m_trig = 1'b0;
  bit m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cap.delete();
      m_prev  = 0;
      m_ready = 1'b0;
      m_trig  = 1'b0;
      m_rd    = 0;
      m_armed = 0;
      m_post  = 0;
      m_tidx  = 0;
    end else begin
      if (!m_ready || int'(rd_x) >= DEPTH) m_rd = 0;
      else m_rd = m_show[int'(rd_x)];
      m_cur = int'(sample_data);
      m_lvl = int'(trig_level);
      case (m_phase)
        0: if (arm) begin
          m_phase = 1;
          m_cap.delete();
        end
        1: if (sample_valid) begin
          m_cap.push_back(m_cur);
          if (m_cap.size() == PT) begin
            m_phase = 2;
            m_armed = 0;
          end
        end
        2: if (sample_valid) begin
          m_hit = trig_rising ? (m_prev < m_lvl && m_cur >= m_lvl)
                              : (m_prev >= m_lvl && m_cur < m_lvl);
          m_armed++;
`ifdef WAVE_AUTO_TRIG_EN
          if (m_armed == AUTO_TO) m_hit = 1'b1;
`endif
          m_cap.push_back(m_cur);
          if (m_hit) begin
            m_tidx  = m_cap.size() - 1;
            m_trig  = 1'b1;
            m_post  = 0;
            m_phase = (POST_N == 0) ? 4 : 3;
          end
        end
        3: if (sample_valid) begin
          m_cap.push_back(m_cur);
          m_post++;
          if (m_post == POST_N) m_phase = 4;
        end
        4: if (frame_sync) begin
          // Column i shows the sample PT before the trigger, plus i.
          for (int i = 0; i < DEPTH; i++)
            m_show[i] = m_cap[m_tidx - PT + i];
          m_ready = 1'b1;
          m_trig  = 1'b0;
          m_phase = single_shot ? 0 : 1;
          m_cap.delete();
        end
        default: m_phase = 0;
      endcase
      if (sample_valid) m_prev = m_cur;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data", int'(rd_data), m_rd);
      check("frame_ready", int'(frame_ready), int'(m_ready));
      check("triggered", int'(triggered), int'(m_trig));
      check("busy", int'(busy), int'(m_phase != 0));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] gen(input int s);
    case (mode)
      0: return 8'(s % 256);
      1: return 8'(255 - s % 256);
      2: return 8'd50;
      4: return (s == 650) ? 8'd200 : 8'(s % 100);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic step();
    logic v;
    v = ($urandom_range(99) < valid_pct) && !arm;
    sample_valid = v;
    if (v) begin
      sample_data = gen(seq);
      seq++;
    end else begin
      sample_data = 8'($urandom);
    end
    frame_sync = fs_once || (fs_auto && (cyc % FS_PERIOD == FS_PERIOD - 1));
    if (rd_fix >= 0) rd_x = 10'(rd_fix);
    else if ($urandom_range(9) == 0) rd_x = 10'($urandom_range(1023, 640));
    else rd_x = 10'($urandom_range(639));
    @(negedge clk);
    cyc++;
    arm = 1'b0;
    fs_once = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    frame_sync = 1'b0;
    fs_auto = 1'b0;
    fs_once = 1'b0;
    rd_fix = -1;
    single_shot = 1'b0;
    valid_pct = 80;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    seq = 0;
    cyc = 0;
    @(negedge clk);
  endtask

  // which: 0 waits for frame_ready, 1 waits for triggered
  task automatic wait_for(input int which, input int budget, input string name);
    int n = 0;
    while (!(which == 0 ? frame_ready : triggered) && n < budget) begin
      step();
      n++;
    end
    check(name, int'(which == 0 ? frame_ready : triggered), 1);
  endtask

  task automatic read_at(input int x, input int exp, input string name);
    rd_fix = x;
    step();
    check(name, int'(rd_data), exp);
    rd_fix = -1;
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_triggered", int'(triggered), 0);
    check("rst_busy", int'(busy), 0);

    // rising ramp, continuous
    mode = 0; trig_level = 8'd128; trig_rising = 1'b1; fs_auto = 1'b1;
    arm = 1'b1; step();
    wait_for(0, 5000, "s1_ready");
    fs_auto = 1'b0;
    read_at(PT, UP_T, "s1_rd64");
    read_at(PT - 1, UP_T - 1, "s1_rd63");
    fs_auto = 1'b1;
    repeat (3000) step();

    // falling ramp, frame_sync on last POST sample, then real swap
    do_reset();
    mode = 1; trig_level = 8'd100; trig_rising = 1'b0; valid_pct = 100;
    arm = 1'b1; step();
    wait_for(1, 3000, "s2_trig");
    repeat (POST_N - 1) step();
    fs_once = 1'b1; step();
    check("s2_sync_last_post_ready", int'(frame_ready), 0);
    check("s2_sync_last_post_trig", int'(triggered), 1);
    repeat (3) step();
    fs_once = 1'b1; step();
    check("s2_swap_ready", int'(frame_ready), 1);
    check("s2_trig_cleared", int'(triggered), 0);
    read_at(PT, DN_T, "s2_rd64");
    read_at(PT - 1, DN_T + 1, "s2_rd63");

    // constant input below level
    do_reset();
    mode = 2; trig_level = 8'd128; trig_rising = 1'b1; fs_auto = 1'b1;
    arm = 1'b1; step();
    repeat (10 * FS_PERIOD) step();
`ifdef WAVE_AUTO_TRIG_EN
    check("s3_auto_ready", int'(frame_ready), 1);
`else
    check("s3_no_frame", int'(frame_ready), 0);
    check("s3_still_busy", int'(busy), 1);
`endif

    // single shot: frame frozen while input keeps changing
    do_reset();
    mode = 0; trig_level = 8'd128; trig_rising = 1'b1;
    single_shot = 1'b1; fs_auto = 1'b1;
    arm = 1'b1; step();
    wait_for(0, 5000, "s4_ready");
    check("s4_idle", int'(busy), 0);
    read_at(PT, UP_T, "s4_rd64");
    mode = 3;
    rd_fix = PT;
    repeat (3 * FS_PERIOD) step();
    check("s4_stable", int'(rd_data), UP_T);
    check("s4_still_idle", int'(busy), 0);
    rd_fix = -1;

    // trigger at write slot 10: start wraps to 586
    do_reset();
    mode = 4; trig_level = 8'd128; trig_rising = 1'b1;
    single_shot = 1'b1; fs_auto = 1'b1;
    arm = 1'b1; step();
    wait_for(0, 6000, "s5_ready");
    read_at(0, S5_R0, "s5_rd0");
    read_at(PT, S5_T, "s5_rd64");
    read_at(DEPTH - 1, S5_END, "s5_rd639");
    read_at(DEPTH, 0, "s5_rd640");
    read_at(1023, 0, "s5_rd1023");

    // reset during POST, arm ignored mid-capture
    do_reset();
    mode = 0; trig_level = 8'd128; trig_rising = 1'b1; fs_auto = 1'b1;
    arm = 1'b1; step();
    wait_for(0, 5000, "s6_ready");
    wait_for(1, 3000, "s6_post");
    arm = 1'b1; step();
    check("s6_arm_ignored", int'(triggered), 1);
    repeat (5) step();
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_ready", int'(frame_ready), 0);
    check("s6_rst_rd", int'(rd_data), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_trig", int'(triggered), 0);
    #2 rst_n = 1'b1;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
